// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states, round constants, S-box and
// the byte-level helpers used by the round and key-schedule datapaths.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    localparam int NR    = 10;
    localparam int BLK_W = 128;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    // Round constant for key-schedule step r (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r rotates left by r: out col c row r = in col (c+r)%4 row r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the current one.
module aes_key_step (
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_in;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_subbytes #(.NB(4)) u_subword (
        .din  (rot_w3),
        .dout (sub_w3)
    );

    assign n0 = w0 ^ sub_w3 ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_subbytes.sv
// Byte-parallel S-box substitution over NB bytes.
module aes_subbytes
#(
    parameter int NB = 16
) (
    input  logic [8*NB-1:0] din,
    output logic [8*NB-1:0] dout
);
    import aes_pkg::*;

    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/encryption_for.sv
// One full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module encryption_for (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);
    import aes_pkg::*;

    logic [127:0] sub_q;
    logic [127:0] shifted;
    logic [127:0] mixed;

    aes_subbytes #(.NB(16)) u_sub (
        .din  (state_in),
        .dout (sub_q)
    );

    assign shifted = shift_rows(sub_q);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
    end

    assign state_out = mixed ^ round_key;

endmodule

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, key schedule
// computed on the fly, one block in flight with valid/ready on both sides.
module aes_enc_iter_ctrl
#(
    parameter int NR      = 10,
    parameter bit ZEROIZE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round_idx
);
    import aes_pkg::*;

    if (NR != aes_pkg::NR) begin : g_nr_check
        $error("aes_enc_iter_ctrl: only NR=10 (AES-128) is supported");
    end

    fsm_t             fsm;
    logic [BLK_W-1:0] state_q;
    logic [BLK_W-1:0] rk_q;
    logic [7:0]       rcon_cur;
    logic [BLK_W-1:0] next_key;
    logic [BLK_W-1:0] round_out;
    logic [BLK_W-1:0] final_sub;
    logic [BLK_W-1:0] final_sr;

    // The same key step serves rounds 1..9 and the final round; round_idx picks rcon.
    assign rcon_cur = rcon(round_idx);

    aes_key_step u_key_step (
        .rk_in  (rk_q),
        .rcon   (rcon_cur),
        .rk_out (next_key)
    );

    encryption_for u_round (
        .state_in  (state_q),
        .round_key (next_key),
        .state_out (round_out)
    );

    aes_subbytes #(.NB(16)) u_final_sub (
        .din  (state_q),
        .dout (final_sub)
    );

    // Final-round ShiftRows wiring: out col c row r = in col (c+r)%4 row r.
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
        for (genvar r = 0; r < 4; r++) begin : g_sr_row
            assign final_sr[127 - 8*(4*c + r) -: 8] =
                final_sub[127 - 8*(4*((c + r) % 4) + r) -: 8];
        end
    end

    assign ciphertext = state_q;

    // Control FSM with registered handshake/status outputs and the state/key registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= S_IDLE;
            state_q   <= '0;
            rk_q      <= '0;
            round_idx <= 4'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        state_q   <= plaintext ^ key;
                        rk_q      <= key;
                        round_idx <= 4'd1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        fsm       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q   <= round_out;
                    rk_q      <= next_key;
                    round_idx <= round_idx + 4'd1;
                    if (round_idx == 4'd9) begin
                        fsm <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    state_q   <= final_sr ^ next_key;
                    rk_q      <= next_key;
                    round_idx <= 4'd10;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    fsm       <= S_DONE;
                end
                S_DONE: begin
                    // in_valid is deliberately ignored here; only the output handshake matters.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        round_idx <= 4'd0;
                        fsm       <= S_IDLE;
                        if (ZEROIZE) begin
                            state_q <= '0;
                            rk_q    <= '0;
                        end
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
`timescale 1ns/1ps
// Directed bench for aes_enc_iter_ctrl with a ciphertext scoreboard.
module tb_aes_enc_iter_ctrl;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round_idx;

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] sb_q[$];

    always #5 clk = ~clk;

    aes_enc_iter_ctrl #(.NR(10), .ZEROIZE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer a block once in_ready is seen; the expected ciphertext enters the scoreboard on accept.
    task automatic accept(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_i("accept_in_ready", int'(in_ready), 1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        sb_q.push_back(ct);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
        check_i("done_timeout", int'(out_valid), 1);
    endtask

    task automatic pop_check(input string tag);
        logic [127:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 128'bx;
        check(tag, ciphertext, exp);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int n;
        int n_acc;
        int n_out;
        int first_acc;
        int second_acc;
        int seen;
        logic acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;

        // Reset values while rst is held
        tick(); tick();
        check_i("rst_in_ready", int'(in_ready), 0);
        check_i("rst_out_valid", int'(out_valid), 0);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_round_idx", int'(round_idx), 0);
        check("rst_ciphertext", ciphertext, 128'h0);
        rst = 1'b0;
        tick();
        check_i("idle_in_ready", int'(in_ready), 1);

        // FIPS-197 App.B with latency: out_valid rises on the 11th edge counting the accept edge
        accept(PT_B, KEY_B, CT_B);
        check("b_initial_ark", ciphertext, PT_B ^ KEY_B);
        check_i("b_round1", int'(round_idx), 1);
        check_i("b_busy", int'(busy), 1);
        check_i("b_in_ready_low", int'(in_ready), 0);
        wait_done(edges);
        check_i("b_latency", edges, 10);
        check_i("b_round_done", int'(round_idx), 10);
        check_i("b_busy_done", int'(busy), 0);
        pop_check("b_ct");
        release_out();
        check_i("b_idle_in_ready", int'(in_ready), 1);
        check_i("b_out_valid_low", int'(out_valid), 0);
        check_i("b_round_idx_zero", int'(round_idx), 0);
        check("b_zeroized", ciphertext, 128'h0);

        // FIPS-197 App.C.1 with round_idx trace
        accept(PT_C, KEY_C, CT_C);
        for (int k = 1; k <= 10; k++) begin
            check_i("c_round_idx", int'(round_idx), k);
            check_i("c_no_early_valid", int'(out_valid), 0);
            tick();
        end
        check_i("c_out_valid", int'(out_valid), 1);
        pop_check("c_ct");
        release_out();

        // Backpressure: result held 20 cycles, in_valid ignored in S_DONE
        accept(PT_B, KEY_B, CT_B);
        wait_done(edges);
        in_valid = 1'b1; plaintext = PT_C; key = KEY_C;
        for (int i = 0; i < 20; i++) begin
            check_i("bp_out_valid", int'(out_valid), 1);
            check("bp_ct_stable", ciphertext, CT_B);
            check_i("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        pop_check("bp_ct");
        release_out();
        check_i("bp_idle_in_ready", int'(in_ready), 1);
        check_i("bp_out_valid_low", int'(out_valid), 0);
        check("bp_zeroized", ciphertext, 128'h0);

        // Back-to-back with out_ready held high
        out_ready = 1'b1; plaintext = PT_B; key = KEY_B; in_valid = 1'b1;
        n_acc = 0; n_out = 0; first_acc = -1; second_acc = -1;
        for (int e = 0; e < 60 && n_out < 2; e++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                if (n_acc == 0) begin
                    sb_q.push_back(CT_B);
                    first_acc = e;
                    plaintext = PT_C; key = KEY_C;
                end else begin
                    sb_q.push_back(CT_C);
                    second_acc = e;
                    in_valid = 1'b0;
                end
                n_acc++;
            end
            if (out_valid) begin
                pop_check("b2b_ct");
                n_out++;
            end
        end
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check_i("b2b_outputs", n_out, 2);
        check_i("b2b_accept_gap", second_acc - first_acc, 12);
        check_i("b2b_idle_in_ready", int'(in_ready), 1);

        // Inputs changed mid-run must not affect the result
        accept(PT_B, KEY_B, CT_B);
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check_i("chg_round5", int'(round_idx), 5);
        plaintext = ~PT_B; key = PT_C;
        wait_done(edges);
        pop_check("chg_ct");
        release_out();

        // Asynchronous reset mid-run discards the block
        accept(PT_B, KEY_B, CT_B);
        n = 0;
        while (round_idx != 4'd6 && n < 20) begin
            tick();
            n++;
        end
        check_i("rr_round6", int'(round_idx), 6);
        rst = 1'b1;
        #1;
        check_i("rr_in_ready", int'(in_ready), 0);
        check_i("rr_out_valid", int'(out_valid), 0);
        check_i("rr_busy", int'(busy), 0);
        check_i("rr_round_idx", int'(round_idx), 0);
        check("rr_ciphertext", ciphertext, 128'h0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_i("rr_no_out_valid", seen, 0);
        accept(PT_B, KEY_B, CT_B);
        wait_done(edges);
        check_i("rr_latency", edges, 10);
        pop_check("rr_ct");
        release_out();

        check_i("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
